// File: rtl/phy_tx_pkg.sv
// Shared definitions for the PHY transmit serializer: comma byte, FSM encoding
// and the default length of the post-reset comma run.
package phy_tx_pkg;

  localparam logic [7:0] COMMA_BC = 8'hBC;
  localparam int SYNC_BCS_DEFAULT = 4;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/phy_tx_shifter.sv
// 8-bit load/shift register with a 0..7 bit counter; data_out is the MSB and
// boundary flags the edge on which the next byte is loaded.
module phy_tx_shifter
  import phy_tx_pkg::*;
(
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] load_byte,
  output logic       data_out,
  output logic       boundary
);

  logic [7:0] sh;
  logic [2:0] bit_cnt;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sh      <= COMMA_BC;
      bit_cnt <= 3'd0;
    end else if (bit_cnt == 3'd7) begin
      sh      <= load_byte;
      bit_cnt <= 3'd0;
    end else begin
      sh      <= {sh[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign boundary = (bit_cnt == 3'd7);
  assign data_out = sh[7];

endmodule

// File: rtl/phy_tx_serializer.sv
// Transmit serializer: comma run after reset, then payload/comma byte slots
// shifted MSB-first. Optional payload byte counter under TX_BYTE_CNT_EN.
module phy_tx_serializer
  import phy_tx_pkg::*;
#(
  parameter int SYNC_BCS = SYNC_BCS_DEFAULT
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out,
`ifdef TX_BYTE_CNT_EN
  output logic        active_out,
  output logic [15:0] byte_cnt_out
`else
  output logic        active_out
`endif
);

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_BCS);

  tx_state_e  state, state_next;
  logic [3:0] sync_cnt, sync_cnt_next;
  logic [7:0] hold;
  logic       hold_v;
  logic [7:0] load_byte;
  logic       load_payload;
  logic       boundary;
  logic       accept;

  phy_tx_shifter u_shifter (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .load_byte (load_byte),
    .data_out  (data_out),
    .boundary  (boundary)
  );

  assign ready_out = (state == RUN) && !hold_v;
  assign accept    = valid_in && ready_out;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) state <= SYNC;
    else        state <= state_next;
  end

  // hold_v is only ever set in RUN, so the slot that ends SYNC always loads a comma
  always_comb begin
    state_next    = state;
    sync_cnt_next = sync_cnt;
    load_byte     = COMMA_BC;
    load_payload  = 1'b0;
    if (boundary) begin
      if (state == SYNC) begin
        sync_cnt_next = sync_cnt + 4'd1;
        if (sync_cnt_next == SYNC_LAST) state_next = RUN;
      end
      if (hold_v) begin
        load_byte    = hold;
        load_payload = 1'b1;
      end
    end
  end

  // Accept and drain never coincide: accept needs hold empty, drain needs it full
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sync_cnt   <= 4'd0;
      hold       <= 8'd0;
      hold_v     <= 1'b0;
      active_out <= 1'b0;
    end else begin
      sync_cnt <= sync_cnt_next;
      if (accept) begin
        hold   <= data_in;
        hold_v <= 1'b1;
      end else if (load_payload) begin
        hold_v <= 1'b0;
      end
      if (boundary) active_out <= load_payload;
    end
  end

`ifdef TX_BYTE_CNT_EN
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset)                                      byte_cnt_out <= 16'd0;
    else if (load_payload && byte_cnt_out != 16'hFFFF) byte_cnt_out <= byte_cnt_out + 16'd1;
  end
`endif

endmodule
